// File: rtl/pipelined_processor.sv
// 4-stage (IF, ID, EX, WB) scalar datapath with a 16x32 register file, running ADD/SUB/AND/LOAD.
// Optional macro FORWARD_EN adds ID operand bypassing from the EX and EX/WB stages.
module pipelined_processor #(
    parameter int NREGS = 16,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     instruction,
    input  logic [XLEN-1:0] data_in,
    output logic [XLEN-1:0] result
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_LOAD = 4'd3;

    logic [XLEN-1:0] regs [NREGS];

    // IF stage register
    logic            if_valid;
    logic [31:0]     if_instr;
    logic [XLEN-1:0] if_data;

    // ID/EX stage register
    logic            ex_valid;
    logic [3:0]      ex_op;
    logic [3:0]      ex_rd;
    logic [XLEN-1:0] ex_a;
    logic [XLEN-1:0] ex_b;
    logic [XLEN-1:0] ex_data;

    // EX/WB stage register
    logic            wb_valid;
    logic            wb_we;
    logic [3:0]      wb_rd;
    logic [XLEN-1:0] wb_val;

    logic [3:0]      id_op;
    logic            id_bsel;
    logic [3:0]      id_rs1;
    logic [3:0]      id_rs2;
    logic [14:0]     id_imm;
    logic [XLEN-1:0] id_rs1_val;
    logic [XLEN-1:0] id_rs2_val;
    logic [XLEN-1:0] id_b;

    logic            ex_we;
    logic [XLEN-1:0] ex_alu;

    assign id_op   = if_instr[31:28];
    assign id_bsel = if_instr[27];
    assign id_rs1  = if_instr[22:19];
    assign id_rs2  = if_instr[18:15];
    assign id_imm  = if_instr[14:0];

    // Opcodes 4..15 are NOPs; only 0..3 write a register.
    assign ex_we = ex_valid && (ex_op[3:2] == 2'b00);

    always_comb begin
        ex_alu = '0;
        case (ex_op)
            OP_ADD:  ex_alu = ex_a + ex_b;
            OP_SUB:  ex_alu = ex_a - ex_b;
            OP_AND:  ex_alu = ex_a & ex_b;
            OP_LOAD: ex_alu = ex_data;
            default: ex_alu = '0;
        endcase
    end

`ifdef FORWARD_EN
    // Youngest producer wins: EX output, then EX/WB, then the register array.
    always_comb begin
        id_rs1_val = regs[id_rs1];
        id_rs2_val = regs[id_rs2];
        if (ex_we && (ex_rd == id_rs1)) begin
            id_rs1_val = ex_alu;
        end else if (wb_valid && wb_we && (wb_rd == id_rs1)) begin
            id_rs1_val = wb_val;
        end
        if (ex_we && (ex_rd == id_rs2)) begin
            id_rs2_val = ex_alu;
        end else if (wb_valid && wb_we && (wb_rd == id_rs2)) begin
            id_rs2_val = wb_val;
        end
    end
`else
    // A producer three issues back was written on this consumer's capture edge,
    // so the plain array read already returns the new value.
    always_comb begin
        id_rs1_val = regs[id_rs1];
        id_rs2_val = regs[id_rs2];
    end
`endif

    assign id_b = id_bsel ? id_rs2_val : {{(XLEN-15){1'b0}}, id_imm};

    always_ff @(posedge clk) begin
        if (!reset) begin
            if_valid <= 1'b0;
            if_instr <= '0;
            if_data  <= '0;
            ex_valid <= 1'b0;
            ex_op    <= '0;
            ex_rd    <= '0;
            ex_a     <= '0;
            ex_b     <= '0;
            ex_data  <= '0;
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
            wb_rd    <= '0;
            wb_val   <= '0;
            result   <= '0;
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if_valid <= 1'b1;
            if_instr <= instruction;
            if_data  <= data_in;

            ex_valid <= if_valid;
            ex_op    <= id_op;
            ex_rd    <= if_instr[26:23];
            ex_a     <= id_rs1_val;
            ex_b     <= id_b;
            ex_data  <= if_data;

            wb_valid <= ex_valid;
            wb_we    <= ex_we;
            wb_rd    <= ex_rd;
            wb_val   <= ex_alu;

            if (wb_valid && wb_we) begin
                regs[wb_rd] <= wb_val;
                result      <= wb_val;
            end
        end
    end

endmodule

// File: tb/tb_pipelined_processor.sv
// Self-checking bench for pipelined_processor: directed scenarios plus random streams
// checked against an architectural model with a visibility lag.
module tb_pipelined_processor;

    logic        clk;
    logic        reset;
    logic [31:0] instruction;
    logic [31:0] data_in;
    logic [31:0] result;

    int n_checks = 0;
    int n_fail   = 0;

    pipelined_processor dut (
        .clk         (clk),
        .reset       (reset),
        .instruction (instruction),
        .data_in     (data_in),
        .result      (result)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        n_fail++;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1);
    end

    // ---------------- reference model ----------------
    // A consumer sees a producer's write once it was issued LAG or more clocks earlier.
`ifdef FORWARD_EN
    localparam int LAG = 1;
`else
    localparam int LAG = 3;
`endif

    typedef struct {
        logic        we;
        logic [3:0]  rd;
        logic [31:0] val;
    } wr_t;

    wr_t         pend[$];
    logic [31:0] m_regs [16];
    logic [31:0] exp_q[$];
    logic [31:0] exp_result = 32'd0;

    task automatic model_edge(input logic rst, input logic [31:0] ins, input logic [31:0] din);
        wr_t         w;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] tail;
        if (!rst) begin
            for (int i = 0; i < 16; i++) m_regs[i] = 32'd0;
            pend.delete();
            exp_q.delete();
            exp_result = 32'd0;
            return;
        end
        while (pend.size() >= LAG) begin
            w = pend.pop_front();
            if (w.we) m_regs[w.rd] = w.val;
        end
        a = m_regs[ins[22:19]];
        b = ins[27] ? m_regs[ins[18:15]] : {17'd0, ins[14:0]};
        w.we = 1'b1;
        w.rd = ins[26:23];
        case (ins[31:28])
            4'd0:    w.val = a + b;
            4'd1:    w.val = a - b;
            4'd2:    w.val = a & b;
            4'd3:    w.val = din;
            default: begin w.we = 1'b0; w.val = 32'd0; end
        endcase
        pend.push_back(w);
        // exp_q holds the value result will show three edges after each capture.
        if (exp_q.size() == 3) exp_result = exp_q.pop_front();
        tail = (exp_q.size() != 0) ? exp_q[$] : exp_result;
        exp_q.push_back(w.we ? w.val : tail);
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    function automatic logic [31:0] enc(input int op, input int bsel, input int rd,
                                        input int rs1, input int rs2, input int imm);
        return {op[3:0], bsel[0], rd[3:0], rs1[3:0], rs2[3:0], imm[14:0]};
    endfunction

    function automatic logic [31:0] nop_i();
        return enc(4, 0, 0, 0, 0, 0);
    endfunction

    task automatic step(input logic rst, input logic [31:0] ins, input logic [31:0] din);
        reset       = rst;
        instruction = ins;
        data_in     = din;
        @(posedge clk);
        model_edge(rst, ins, din);
        #1;
        check("result_model", result, exp_result);
    endtask

    task automatic issue(input logic [31:0] ins, input logic [31:0] din);
        step(1'b1, ins, din);
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) step(1'b1, nop_i(), $urandom);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(1'b0, enc(0, 0, 1, 0, 0, 9), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset       = 1'b0;
        instruction = 32'd0;
        data_in     = 32'd0;

        // Reset holds: ADD r1,r0,#9 on the bus is ignored.
        do_reset(2);
        check("reset_result", result, 32'd0);
        issue(enc(1, 0, 2, 1, 0, 0), 32'd0);
        nops(3);
        check("reset_r1_zero", result, 32'd0);

        // Latency: result appears exactly 3 edges after capture, then holds.
        do_reset(1);
        issue(enc(0, 0, 1, 0, 0, 9), 32'd0);
        nops(2);
        check("latency_early", result, 32'd0);
        nops(1);
        check("latency_9", result, 32'd9);
        nops(2);
        check("latency_hold", result, 32'd9);

        // Back-to-back dependent stream.
        do_reset(1);
        issue(enc(0, 0, 1, 0, 0, 9), 32'd0);
        issue(enc(1, 0, 2, 1, 0, 3), 32'd0);
        issue(enc(2, 0, 3, 2, 0, 5), 32'd0);
        issue(enc(3, 0, 4, 0, 0, 0), 32'd10);
        check("b2b_add", result, 32'd9);
        issue(enc(0, 1, 5, 4, 1, 0), 32'd0);
`ifdef FORWARD_EN
        check("b2b_sub", result, 32'd6);
        nops(1);
        check("b2b_and", result, 32'd4);
        nops(1);
        check("b2b_load", result, 32'd10);
        nops(1);
        check("b2b_add_rr", result, 32'd19);
`else
        check("b2b_sub_stale", result, 32'hFFFF_FFFD);
        nops(1);
        check("b2b_and_stale", result, 32'd0);
        nops(1);
        check("b2b_load", result, 32'd10);
        nops(1);
        check("b2b_add_rr", result, 32'd9);
`endif
        nops(2);

        // Same stream with two NOPs between each pair.
        do_reset(1);
        issue(enc(0, 0, 1, 0, 0, 9), 32'd0);
        nops(2);
        issue(enc(1, 0, 2, 1, 0, 3), 32'd0);
        check("spaced_add", result, 32'd9);
        nops(2);
        issue(enc(2, 0, 3, 2, 0, 5), 32'd0);
        check("spaced_sub", result, 32'd6);
        nops(2);
        issue(enc(3, 0, 4, 0, 0, 0), 32'd10);
        check("spaced_and", result, 32'd4);
        nops(3);
        check("spaced_load", result, 32'd10);

        // Wrap-around.
        do_reset(1);
        issue(enc(1, 0, 1, 0, 0, 1), 32'd0);
        nops(3);
        check("wrap_sub", result, 32'hFFFF_FFFF);
        issue(enc(0, 0, 1, 1, 0, 1), 32'd0);
        nops(3);
        check("wrap_add", result, 32'h0000_0000);

        // Flush: three ADDs in flight are discarded by a 1-clock reset pulse.
        do_reset(1);
        issue(enc(0, 0, 15, 0, 0, 7), 32'd0);
        nops(3);
        check("flush_pre", result, 32'd7);
        issue(enc(0, 0, 0, 0, 0, 5), 32'd0);
        issue(enc(0, 0, 3, 0, 0, 7), 32'd0);
        issue(enc(0, 0, 4, 0, 0, 1), 32'd0);
        do_reset(1);
        check("flush_result", result, 32'd0);
        for (int r = 0; r < 16; r++) begin
            issue(enc(0, 0, r, r, 0, 0), 32'd0);
            nops(3);
            check($sformatf("flush_r%0d", r), result, 32'd0);
        end

        // Randomised streams with occasional reset pulses.
        do_reset(1);
        for (int i = 0; i < 1500; i++) begin
            logic rst_b;
            rst_b = ($urandom_range(0, 59) != 0);
            step(rst_b,
                 enc($urandom_range(0, 5), $urandom_range(0, 1), $urandom_range(0, 15),
                     $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 32767)),
                 $urandom);
        end
        nops(4);

        // ---------------- final report ----------------
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
